// File: rtl/arm_control_unit_pkg.sv
// Shared encodings for the ARM control unit: ALU ops, immediate formats,
// opcode classes, data-processing cmd codes, condition codes, FSM states.
package arm_ctrl_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/arm_control_unit_if.sv
// Control interface between the single-cycle datapath (master) and the
// control unit (slave). Flags are ordered {N,Z,C,V}.
interface arm_control_unit_if #(parameter int FLAG_W = 4);
  logic [31:0]       Instr;
  logic [FLAG_W-1:0] ALUFlags;
  logic              PCSrc;
  logic              MemtoReg;
  logic              MemWrite;
  logic [1:0]        ALUControl;
  logic [1:0]        ALUSrc;
  logic [1:0]        ImmSrc;
  logic              RegWrite;
  logic [1:0]        RegSrc;
  logic [FLAG_W-1:0] Flags;
  logic              CondEx;

  modport master (
    output Instr, ALUFlags,
    input  PCSrc, MemtoReg, MemWrite, ALUControl, ALUSrc, ImmSrc,
    input  RegWrite, RegSrc, Flags, CondEx
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCSrc, MemtoReg, MemWrite, ALUControl, ALUSrc, ImmSrc,
    output RegWrite, RegSrc, Flags, CondEx
  );
endinterface

// File: rtl/arm_control_unit_cond_check.sv
// ARM condition-code evaluator: combinational, Cond and {N,Z,C,V} in.
module cond_check
  import arm_ctrl_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags[3:0];

  // Standard EQ..LE table, AL always true, 1111 never
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_control_unit.sv
// Control unit for the single-cycle ARM datapath: instruction decode,
// NZCV flag register and conditional execution gating.
// Optional macro CTRL_CMP_EN adds CMP (cmd 1010) and TST (cmd 1000).
module arm_control_unit
  import arm_ctrl_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input logic             CLK,
  input logic             RST_N,
  arm_control_unit_if.slave bus
);

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic [5:0] funct;
  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign cmd   = bus.Instr[24:21];
  assign rd    = bus.Instr[15:12];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};

  state_e            state_q, state_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  logic [1:0] alu_ctrl, alu_src, imm_src, reg_src, flag_w;
  logic       reg_w, mem_w, mem_to_reg, pcs;
  logic       cond_ok, cond_ex;

  // Instruction decode into raw (ungated) controls
  always_comb begin
    alu_ctrl   = ALU_ADD;
    alu_src    = 2'b00;
    imm_src    = IMM_8;
    reg_src    = 2'b00;
    flag_w     = 2'b00;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    mem_to_reg = 1'b0;
    pcs        = 1'b0;
    case (op)
      OP_DP: begin
        alu_src = {1'b0, funct[5]};
        case (cmd)
          CMD_ADD: begin alu_ctrl = ALU_ADD; reg_w = 1'b1; flag_w = {2{funct[0]}}; end
          CMD_SUB: begin alu_ctrl = ALU_SUB; reg_w = 1'b1; flag_w = {2{funct[0]}}; end
          CMD_AND: begin alu_ctrl = ALU_AND; reg_w = 1'b1; flag_w = {funct[0], 1'b0}; end
          CMD_ORR: begin alu_ctrl = ALU_ORR; reg_w = 1'b1; flag_w = {funct[0], 1'b0}; end
`ifdef CTRL_CMP_EN
          CMD_CMP: begin alu_ctrl = ALU_SUB; flag_w = 2'b11; end
          CMD_TST: begin alu_ctrl = ALU_AND; flag_w = 2'b10; end
`endif
          default: ;
        endcase
      end
      OP_MEM: begin
        alu_src  = 2'b01;
        imm_src  = IMM_12;
        alu_ctrl = funct[3] ? ALU_ADD : ALU_SUB;
        if (funct[0]) begin
          mem_to_reg = 1'b1;
          reg_w      = 1'b1;
        end else begin
          mem_w   = 1'b1;
          reg_src = 2'b10;
        end
      end
      OP_BR: begin
        pcs     = 1'b1;
        alu_src = 2'b01;
        imm_src = IMM_24;
        reg_src = 2'b01;
      end
      default: ;
    endcase
  end

  cond_check #(.FLAG_W(FLAG_W)) u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ok)
  );

  // HOLD leaves one bubble after reset; RUN is sticky until the next reset
  always_comb begin
    state_d = state_q;
    cond_ex = 1'b0;
    case (state_q)
      HOLD: state_d = RUN;
      RUN:  cond_ex = cond_ok;
      default: state_d = HOLD;
    endcase
  end

  // Flag halves load independently, only when the instruction executes
  always_comb begin
    flags_d = flags_q;
    if (cond_ex && flag_w[1]) flags_d[3:2] = bus.ALUFlags[3:2];
    if (cond_ex && flag_w[0]) flags_d[1:0] = bus.ALUFlags[1:0];
  end

  // State and flag registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= HOLD;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Every output is forced low while reset is asserted
  assign bus.PCSrc      = RST_N & (pcs | (reg_w & (rd == 4'hF))) & cond_ex;
  assign bus.RegWrite   = RST_N & reg_w & cond_ex;
  assign bus.MemWrite   = RST_N & mem_w & cond_ex;
  assign bus.MemtoReg   = RST_N & mem_to_reg;
  assign bus.ALUControl = RST_N ? alu_ctrl : 2'b00;
  assign bus.ALUSrc     = RST_N ? alu_src  : 2'b00;
  assign bus.ImmSrc     = RST_N ? imm_src  : 2'b00;
  assign bus.RegSrc     = RST_N ? reg_src  : 2'b00;
  assign bus.Flags      = flags_q;
  assign bus.CondEx     = RST_N & cond_ex;

endmodule

// File: tb/tb_arm_control_unit.sv
// Scoreboard bench for arm_control_unit: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares every output.
module tb_arm_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arm_control_unit_if #(.FLAG_W(4)) bus ();

  arm_control_unit #(.FLAG_W(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic       pcsrc;
    logic       m2r;
    logic       memw;
    logic [1:0] aluc;
    logic [1:0] alusrc;
    logic [1:0] imm;
    logic       regw;
    logic [1:0] regsrc;
    logic [3:0] flags;
    logic       condex;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(string nm, logic pcs, logic m2r, logic memw,
                              logic [1:0] aluc, logic [1:0] alusrc, logic [1:0] imm,
                              logic regw, logic [1:0] regsrc, logic [3:0] fl, logic cex);
    exp_t e;
    e.name = nm; e.pcsrc = pcs; e.m2r = m2r; e.memw = memw; e.aluc = aluc;
    e.alusrc = alusrc; e.imm = imm; e.regw = regw; e.regsrc = regsrc;
    e.flags = fl; e.condex = cex;
    return e;
  endfunction

  task automatic chk(string nm, string fld, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %b expected %b", nm, fld, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.name, "PCSrc",      {3'b0, bus.PCSrc},      {3'b0, e.pcsrc});
      chk(e.name, "MemtoReg",   {3'b0, bus.MemtoReg},   {3'b0, e.m2r});
      chk(e.name, "MemWrite",   {3'b0, bus.MemWrite},   {3'b0, e.memw});
      chk(e.name, "ALUControl", {2'b0, bus.ALUControl}, {2'b0, e.aluc});
      chk(e.name, "ALUSrc",     {2'b0, bus.ALUSrc},     {2'b0, e.alusrc});
      chk(e.name, "ImmSrc",     {2'b0, bus.ImmSrc},     {2'b0, e.imm});
      chk(e.name, "RegWrite",   {3'b0, bus.RegWrite},   {3'b0, e.regw});
      chk(e.name, "RegSrc",     {2'b0, bus.RegSrc},     {2'b0, e.regsrc});
      chk(e.name, "Flags",      bus.Flags,              e.flags);
      chk(e.name, "CondEx",     {3'b0, bus.CondEx},     {3'b0, e.condex});
    end
  end

  task automatic apply(input logic r, input logic [31:0] ins, input logic [3:0] af, input exp_t e);
    @(posedge clk);
    #1;
    rst_n = r;
    bus.Instr = ins;
    bus.ALUFlags = af;
    sb_q.push_back(e);
  endtask

  localparam logic [31:0] I_ADDS = 32'hE2921005;
  localparam logic [31:0] I_BEQ  = 32'h0A000002;
  localparam logic [31:0] I_OP11 = 32'hEC000000;

  initial begin
    bus.Instr = I_ADDS;
    bus.ALUFlags = 4'b0110;
    //                          pcs m2r mw aluc   alusrc imm    rw rs     flags    cex
    apply(1'b0, I_ADDS, 4'b0110, mk("rst_low",   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 4'b0000, 0));
    apply(1'b1, I_ADDS, 4'b0110, mk("hold",      0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 2'b00, 4'b0000, 0));
    apply(1'b1, I_ADDS, 4'b0110, mk("adds",      0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 2'b00, 4'b0000, 1));
    apply(1'b1, I_BEQ,  4'b0000, mk("beq_taken", 1, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b01, 4'b0110, 1));
    apply(1'b1, I_ADDS, 4'b0000, mk("adds_clrz", 0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 2'b00, 4'b0110, 1));
    apply(1'b1, I_BEQ,  4'b1111, mk("beq_not",   0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b01, 4'b0000, 0));
    apply(1'b1, 32'hE5843008, 4'b1111, mk("str",    0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 2'b10, 4'b0000, 1));
    apply(1'b1, 32'hE594F000, 4'b1111, mk("ldr_pc", 1, 1, 0, 2'b00, 2'b01, 2'b01, 1, 2'b00, 4'b0000, 1));
    apply(1'b1, 32'hE0521003, 4'b1001, mk("subs",   0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 2'b00, 4'b0000, 1));
    apply(1'b1, 32'hE0121003, 4'b0110, mk("ands",   0, 0, 0, 2'b10, 2'b00, 2'b00, 1, 2'b00, 4'b1001, 1));
    apply(1'b1, 32'h41821003, 4'b1111, mk("orr_mi", 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b00, 4'b0101, 0));
    apply(1'b1, 32'h51821003, 4'b1111, mk("orr_pl", 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 2'b00, 4'b0101, 1));
    apply(1'b1, 32'hDC000000, 4'b1111, mk("op11_le",0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 4'b0101, 1));
`ifdef CTRL_CMP_EN
    apply(1'b1, 32'hE3510000, 4'b0100, mk("cmp",    0, 0, 0, 2'b01, 2'b01, 2'b00, 0, 2'b00, 4'b0101, 1));
    apply(1'b1, I_OP11, 4'b1111,       mk("after_cmp", 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 4'b0100, 1));
`else
    apply(1'b1, 32'hE3510000, 4'b0100, mk("cmp",    0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 2'b00, 4'b0101, 1));
    apply(1'b1, I_OP11, 4'b1111,       mk("after_cmp", 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 4'b0101, 1));
`endif
    // Reset dropped mid-cycle with a flag write pending
    apply(1'b1, I_ADDS, 4'b1111, mk("rst_mid", 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 4'b0000, 0));
    #2;
    rst_n = 1'b0;
    apply(1'b1, I_ADDS, 4'b1111, mk("hold2",  0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 2'b00, 4'b0000, 0));
    apply(1'b1, I_ADDS, 4'b1111, mk("adds2",  0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 2'b00, 4'b0000, 1));
    apply(1'b1, I_OP11, 4'b0000, mk("final",  0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 4'b1111, 1));
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/arm_control_unit.md
Name: arm_control_unit

Overview:
- Control unit for the single-cycle ARM calculator datapath (MicroProcessor), the decode end of its control interface.
- Consumes Instr and ALUFlags from the datapath and drives PCSrc, MemtoReg, MemWrite, ALUControl, ALUSrc, ImmSrc, RegWrite and RegSrc back into it.
- Holds the architectural NZCV flag register and evaluates ARM condition codes.
- Replaces the hand-driven control stimulus used in datapath benches.

Parameters:
- FLAG_W, 4, width of the ALUFlags/Flags vectors, ordered {N,Z,C,V}.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- Instr  in  32  current instruction from instruction memory.
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction.
- PCSrc  out  1  1 = PC loads Result (branch or write to R15).
- MemtoReg  out  1  1 = Result comes from ReadData.
- MemWrite  out  1  data memory write enable.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- ALUSrc  out  2  00 = RD2, 01 = ExtImm; 10/11 reserved, never driven.
- ImmSrc  out  2  00 = imm8, 01 = imm12, 10 = imm24 branch offset.
- RegWrite  out  1  register file write enable.
- RegSrc  out  2  bit0 = RA1 selects R15; bit1 = RA2 selects Rd.
- Flags  out  4  registered NZCV, for debug and the bench.
- CondEx  out  1  condition of the current instruction passed.

Behaviour:
- Clock and reset: CLK, rising edge; RST_N asynchronous, active-low.
- Reset state: Flags=0000, FSM in HOLD.
- While RST_N=0, all outputs are 0.
- Field map: Cond=Instr[31:28], Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12], cmd=Instr[24:21].
- FSM: HOLD -> RUN on the first rising CLK with RST_N=1. RUN has no further transitions until the next reset.
- In HOLD, CondEx is forced to 0, so there are no writes, no branch and no flag update. This gives one bubble cycle after reset.
- Op=00, data processing:
  - ALUSrc = 01 if Funct[5] (immediate) else 00; ImmSrc=00; RegSrc=00; RegW=1; MemtoReg=0.
  - cmd 0100 -> ADD, 0010 -> SUB, 0000 -> AND, 1100 -> ORR.
  - Any other cmd is unsupported: RegW=0 and FlagW=00.
- Op=01, memory:
  - ALUSrc=01; ImmSrc=01.
  - ALUControl = 00 if U (Funct[3]) = 1, else 01.
  - L=Funct[0]=1 (LDR): MemtoReg=1, RegW=1, RegSrc=00.
  - L=0 (STR): MemW=1, RegW=0, RegSrc=10.
- Op=10, branch: PCS=1, ALUSrc=01, ImmSrc=10, RegSrc=01, ALUControl=00, RegW=0.
- Op=11: all decoded controls are 0.
- FlagW:
  - FlagW[1] = S (Funct[0]), for data processing only.
  - FlagW[0] = S & (cmd is ADD or SUB).
- Condition evaluation:
  - Evaluated combinationally against the registered Flags, i.e. the values before this instruction's update.
  - Standard ARM table EQ..LE for 0000..1101; AL=1110 is always true; 1111 is false.
- Gated outputs:
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
  - PCSrc = (PCS | (RegW & Rd==4'hF)) & CondEx.
- Flag update, on rising CLK when CondEx:
  - FlagW[1] loads Flags[3:2] <= ALUFlags[3:2].
  - FlagW[0] loads Flags[1:0] <= ALUFlags[1:0].
  - The two halves update independently.
- Ungated outputs: ALUControl, ALUSrc, ImmSrc, RegSrc and MemtoReg are not gated by CondEx.
- Latency: all controls are combinational from Instr in the same cycle. Flags become visible one cycle later.
- Reset mid-operation: outputs go to 0 immediately and Flags clears. A pending flag write is lost.

Optional Feature:
- Macro: CTRL_CMP_EN.
- Defined:
  - cmd 1010 (CMP) decodes as SUB with RegW=0 and FlagW=11 regardless of S.
  - cmd 1000 (TST) decodes as AND with RegW=0 and FlagW=10.
- Undefined: both opcodes are unsupported (RegW=0, FlagW=00).

Decomposition:
- Package arm_ctrl_pkg holds:
  - ALU_ADD/SUB/AND/ORR.
  - IMM_8/IMM_12/IMM_24.
  - OP_DP/OP_MEM/OP_BR.
  - cmd codes and condition-code constants.
  - FSM state encoding (HOLD, RUN).
- Sub-module cond_check: combinational; Cond and Flags in, CondEx out.

Test Plan:
- Reset hold: RST_N low then high, Instr=0xE2921005 -> first cycle RegWrite=0 and Flags unchanged; next cycle RegWrite=1.
- ADDS R1,R2,#5: Instr=0xE2921005, ALUFlags=0110 -> RegWrite=1, ALUSrc=01, ImmSrc=00, ALUControl=00; next cycle Flags=0110.
- BEQ: Instr=0x0A000002 with Flags Z=1 -> PCSrc=1, ImmSrc=10, RegSrc=01. Same instruction with Z=0 -> PCSrc=0, Flags unchanged.
- STR R3,[R4,#8]: Instr=0xE5843008 -> MemWrite=1, RegWrite=0, RegSrc=10, ImmSrc=01, ALUSrc=01, ALUControl=00.
- LDR PC,[R4]: Instr=0xE594F000 -> RegWrite=1, MemtoReg=1, PCSrc=1.
- Mid-run reset: apply RST_N low mid-run -> all outputs 0 and Flags=0000 asynchronously.
- CTRL_CMP_EN: CMP R1,#0, Instr=0xE3510000, ALUFlags=0100.
  - Defined: RegWrite=0 and Flags=0100 next cycle.
  - Undefined: Flags unchanged.
